// File: rtl/calc_seq_alu.sv
// rtl/calc_seq_alu.sv - iterative unsigned ADD/SUB/MUL/DIV calculator with valid/ready handshakes
// MUL and DIV share one 2*WIDTH accumulator: high half is partial product / remainder, low half is multiplier / quotient.
module calc_seq_alu #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] num1,
    input  logic [WIDTH-1:0] num2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             flag
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;

    logic [1:0]         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               div_q, div_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   opb_q, opb_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic [WIDTH-1:0]   result_hi_q, result_hi_d;
    logic               flag_q, flag_d;

    logic [WIDTH:0]     add_sum;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_step;
    logic [WIDTH:0]     div_shift;
    logic               div_ge;
    logic [WIDTH-1:0]   div_diff;
    logic [2*WIDTH-1:0] div_step;

    assign add_sum = {1'b0, num1} + {1'b0, num2};

    // Shift-add: conditionally add multiplicand into the high half, then shift the whole accumulator right.
    assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opb_q};
    assign mul_step = acc_q[0] ? {mul_sum, acc_q[WIDTH-1:1]}
                               : {1'b0, acc_q[2*WIDTH-1:1]};

    // Restoring division: shift next dividend bit into the remainder, subtract if it fits.
    // A zero divisor always "fits", which naturally yields all-ones quotient and remainder = dividend.
    assign div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    assign div_ge    = div_shift >= {1'b0, opb_q};
    assign div_diff  = div_shift[WIDTH-1:0] - opb_q;
    assign div_step  = div_ge ? {div_diff, acc_q[WIDTH-2:0], 1'b1}
                              : {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        div_d       = div_q;
        acc_d       = acc_q;
        opb_d       = opb_q;
        result_d    = result_q;
        result_hi_d = result_hi_q;
        flag_d      = flag_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    if (op == OP_ADD) begin
                        result_d    = add_sum[WIDTH-1:0];
                        result_hi_d = '0;
                        flag_d      = add_sum[WIDTH];
                        state_d     = S_DONE;
                    end else if (op == OP_SUB) begin
                        result_d    = num1 - num2;
                        result_hi_d = '0;
                        flag_d      = num1 < num2;
                        state_d     = S_DONE;
                    end else begin
                        div_d   = (op != OP_MUL);
                        acc_d   = {{WIDTH{1'b0}}, num1};
                        opb_d   = num2;
                        cnt_d   = CNT_W'(WIDTH);
                        state_d = S_BUSY;
                    end
                end
            end
            S_BUSY: begin
                cnt_d = cnt_q - CNT_W'(1);
                acc_d = div_q ? div_step : mul_step;
                if (cnt_q == CNT_W'(1)) begin
                    result_d    = acc_d[WIDTH-1:0];
                    result_hi_d = acc_d[2*WIDTH-1:WIDTH];
                    flag_d      = div_q ? (opb_q == '0) : (|acc_d[2*WIDTH-1:WIDTH]);
                    state_d     = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            div_q       <= 1'b0;
            acc_q       <= '0;
            opb_q       <= '0;
            result_q    <= '0;
            result_hi_q <= '0;
            flag_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            div_q       <= div_d;
            acc_q       <= acc_d;
            opb_q       <= opb_d;
            result_q    <= result_d;
            result_hi_q <= result_hi_d;
            flag_q      <= flag_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign result    = result_q;
    assign result_hi = result_hi_q;
    assign flag      = flag_q;

endmodule
